// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the typing-game controller and its datapath:
// state encodings, control-key scan codes, and the per-mode value limits.
package game_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_SELECT    = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_INGAME    = 2'd2,
        ST_FINISH    = 2'd3
    } game_state_e;

    // Full 9-bit scan codes; bit 8 marks the E0-extended set
    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_ESC   = 9'h076;
    localparam logic [8:0] KEY_UP    = 9'h175;
    localparam logic [8:0] KEY_DOWN  = 9'h172;
    localparam logic [8:0] KEY_LEFT  = 9'h16B;
    localparam logic [8:0] KEY_RIGHT = 9'h174;

    localparam logic MODE_WORDS = 1'b1;
    localparam logic MODE_TIMED = 1'b0;

    // Word-count game limits
    localparam logic [6:0] WORDS_MIN  = 7'd10;
    localparam logic [6:0] WORDS_MAX  = 7'd50;
    localparam logic [6:0] WORDS_STEP = 7'd5;
    localparam logic [6:0] WORDS_DEF  = 7'd20;

    // Timed game limits (seconds)
    localparam logic [6:0] SECS_MIN  = 7'd15;
    localparam logic [6:0] SECS_MAX  = 7'd60;
    localparam logic [6:0] SECS_STEP = 7'd15;
    localparam logic [6:0] SECS_DEF  = 7'd30;

    function automatic logic [6:0] default_value(input logic mode);
        return (mode == MODE_WORDS) ? WORDS_DEF : SECS_DEF;
    endfunction

    // One UP/DOWN step, saturating at the mode's limits
    function automatic logic [6:0] step_value(input logic mode, input logic up,
                                              input logic [6:0] v);
        logic [6:0] lo;
        logic [6:0] hi;
        logic [6:0] st;
        lo = (mode == MODE_WORDS) ? WORDS_MIN  : SECS_MIN;
        hi = (mode == MODE_WORDS) ? WORDS_MAX  : SECS_MAX;
        st = (mode == MODE_WORDS) ? WORDS_STEP : SECS_STEP;
        if (up) begin
            return (v > hi - st) ? hi : v + st;
        end
        return (v < lo + st) ? lo : v - st;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Bundle between the game controller and its surroundings: keyboard decoder
// inputs, the datapath finish flag, and the state/mode/value outputs.
// master = controller side, slave = keyboard/datapath side.
interface game_ctrl_if;
    logic [127:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;
    logic         finish;
    logic [1:0]   state;
    logic         mode;
    logic [6:0]   value;
    logic [1:0]   cd_sec;
    logic         state_chg;

    modport master (
        input  key_down, last_change, key_valid, finish,
        output state, mode, value, cd_sec, state_chg
    );

    modport slave (
        output key_down, last_change, key_valid, finish,
        input  state, mode, value, cd_sec, state_chg
    );
endinterface

// File: rtl/game_ctrl_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_HZ/TICK_HZ clocks.
module tick_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;

    // Wrap the divider at DIV-1; the wrap cycle is the tick
    always_comb begin
        tick  = (div_q == DIV_W'(DIV - 1));
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // Divider register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_q <= '0;
        else        div_q <= div_d;
    end
endmodule

// File: rtl/game_ctrl.sv
// Typing-game sequencer: SELECT -> COUNTDOWN -> INGAME -> FINISH.
// Owns mode/value selection, decodes control keys, runs the countdown.
// Optional feature macro AUTO_RETURN_EN: FINISH returns to SELECT on its own
// after RESULT_SEC seconds (keys still exit early).
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100,
    parameter int CD_SEC  = 3
`ifdef AUTO_RETURN_EN
    , parameter int RESULT_SEC = 10
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    game_ctrl_if.master  gif
);
    localparam int CD_TICKS = CD_SEC * TICK_HZ;
`ifdef AUTO_RETURN_EN
    localparam int HOLD_TICKS = RESULT_SEC * TICK_HZ;
    localparam int CNT_MAX    = (HOLD_TICKS > CD_TICKS) ? HOLD_TICKS : CD_TICKS;
`else
    localparam int CNT_MAX    = CD_TICKS;
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    game_state_e       state_q, state_d;
    logic              mode_q, mode_d;
    logic [6:0]        value_q, value_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              state_chg_q, state_chg_d;
    logic              held_q, held_d;

    logic              tick;
    logic              press;
    logic              k_enter, k_esc, k_up, k_down, k_side;
    logic [CNT_W-1:0]  cnt_dec;
    logic [CNT_W:0]    cd_round;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Key decode: a press is a fresh strobe on a key that was not already held
    always_comb begin
        held_d  = gif.key_down[gif.last_change[6:0]];
        press   = gif.key_valid & held_d & ~held_q;
        k_enter = press && (gif.last_change == KEY_ENTER);
        k_esc   = press && (gif.last_change == KEY_ESC);
        k_up    = press && (gif.last_change == KEY_UP);
        k_down  = press && (gif.last_change == KEY_DOWN);
        k_side  = press && ((gif.last_change == KEY_LEFT) ||
                            (gif.last_change == KEY_RIGHT));
    end

    // Next state, mode/value selection and countdown/hold counter
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        value_d = value_q;
        cnt_d   = cnt_q;
        cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);

        case (state_q)
            ST_SELECT: begin
                if (k_enter) begin
                    state_d = ST_COUNTDOWN;
                    cnt_d   = CNT_W'(CD_TICKS);
                end else if (k_up) begin
                    value_d = step_value(mode_q, 1'b1, value_q);
                end else if (k_down) begin
                    value_d = step_value(mode_q, 1'b0, value_q);
                end else if (k_side) begin
                    mode_d  = ~mode_q;
                    value_d = default_value(~mode_q);
                end
            end
            ST_COUNTDOWN: begin
                if (k_esc) begin
                    state_d = ST_SELECT;
                    cnt_d   = '0;
                end else if (tick) begin
                    // The tick that drains the counter to zero ends the countdown
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) state_d = ST_INGAME;
                end
            end
            ST_INGAME: begin
                if (k_esc) begin
                    state_d = ST_SELECT;
                end else if (gif.finish) begin
                    state_d = ST_FINISH;
`ifdef AUTO_RETURN_EN
                    cnt_d   = CNT_W'(HOLD_TICKS);
`endif
                end
            end
            ST_FINISH: begin
                if (k_esc || k_enter) begin
                    state_d = ST_SELECT;
                    cnt_d   = '0;
`ifdef AUTO_RETURN_EN
                end else if (tick) begin
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) state_d = ST_SELECT;
`endif
                end
            end
            default: state_d = ST_SELECT;
        endcase

        state_chg_d = (state_d != state_q);
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SELECT;
            mode_q      <= MODE_WORDS;
            value_q     <= WORDS_DEF;
            cnt_q       <= '0;
            state_chg_q <= 1'b0;
            held_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            value_q     <= value_d;
            cnt_q       <= cnt_d;
            state_chg_q <= state_chg_d;
            held_q      <= held_d;
        end
    end

    // Seconds remaining, rounded up, shown only during the countdown
    always_comb begin
        cd_round = ({1'b0, cnt_q} + (CNT_W+1)'(TICK_HZ - 1)) / (CNT_W+1)'(TICK_HZ);
        gif.cd_sec = (state_q == ST_COUNTDOWN) ? 2'(cd_round) : 2'd0;
    end

    assign gif.state     = state_q;
    assign gif.mode      = mode_q;
    assign gif.value     = value_q;
    assign gif.state_chg = state_chg_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl, run with a 10-clock tick (CLK_HZ=1000, TICK_HZ=100)
// so the 300-tick countdown takes 3000 clocks.
module tb_game_ctrl;
    import game_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    game_ctrl_if gif ();

    game_ctrl #(
        .CLK_HZ  (1000),
        .TICK_HZ (100),
        .CD_SEC  (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .gif   (gif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clean key press, optionally with finish asserted in the same cycle
    task automatic press(input logic [8:0] code, input logic fin);
        @(negedge clk);
        gif.key_down[code[6:0]] = 1'b1;
        gif.last_change = code;
        gif.key_valid = 1'b1;
        gif.finish = fin;
        @(negedge clk);
        gif.key_valid = 1'b0;
        gif.key_down[code[6:0]] = 1'b0;
        gif.finish = 1'b0;
    endtask

    // Key held down while the decoder keeps strobing key_valid (typematic)
    task automatic press_hold(input logic [8:0] code, input int reps);
        @(negedge clk);
        gif.key_down[code[6:0]] = 1'b1;
        gif.last_change = code;
        gif.key_valid = 1'b1;
        for (int r = 0; r < reps; r++) begin
            @(negedge clk);
            gif.key_valid = 1'b0;
            @(negedge clk);
            gif.key_valid = 1'b1;
        end
        @(negedge clk);
        gif.key_valid = 1'b0;
        gif.key_down[code[6:0]] = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] s, input int limit, output int n);
        n = 0;
        while (gif.state !== s && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int c3, c2, c1, chg;
        int exp_up[10];
        int exp_dn[10];
        exp_up = '{25, 30, 35, 40, 45, 50, 50, 50, 50, 50};
        exp_dn = '{45, 40, 35, 30, 25, 20, 15, 10, 10, 10};

        gif.key_down    = '0;
        gif.last_change = '0;
        gif.key_valid   = 1'b0;
        gif.finish      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_state", 32'(gif.state), 0);
        chk("rst_mode", 32'(gif.mode), 1);
        chk("rst_value", 32'(gif.value), 20);
        chk("rst_cd_sec", 32'(gif.cd_sec), 0);
        chk("rst_state_chg", 32'(gif.state_chg), 0);

        // Value stepping and saturation in word-count mode
        for (int i = 0; i < 10; i++) begin
            press(KEY_UP, 1'b0);
            chk($sformatf("up_%0d", i), 32'(gif.value), 32'(exp_up[i]));
        end
        chk("up_no_chg", 32'(gif.state_chg), 0);
        for (int i = 0; i < 10; i++) begin
            press(KEY_DOWN, 1'b0);
            chk($sformatf("down_%0d", i), 32'(gif.value), 32'(exp_dn[i]));
        end

        // Mode toggle and timed-mode limits
        press(KEY_RIGHT, 1'b0);
        chk("right_mode", 32'(gif.mode), 0);
        chk("right_value", 32'(gif.value), 30);
        press(KEY_DOWN, 1'b0);
        chk("timed_down1", 32'(gif.value), 15);
        press(KEY_DOWN, 1'b0);
        chk("timed_down2", 32'(gif.value), 15);
        press(KEY_UP, 1'b0);
        press(KEY_UP, 1'b0);
        press(KEY_UP, 1'b0);
        chk("timed_up3", 32'(gif.value), 60);
        press(KEY_UP, 1'b0);
        chk("timed_up_sat", 32'(gif.value), 60);
        press(KEY_LEFT, 1'b0);
        chk("left_mode", 32'(gif.mode), 1);
        chk("left_value", 32'(gif.value), 20);

        // Held key with repeated strobes counts once
        press_hold(KEY_UP, 3);
        chk("typematic_value", 32'(gif.value), 25);

        // Full countdown
        press(KEY_ENTER, 1'b0);
        chk("enter_state", 32'(gif.state), 1);
        chk("enter_chg", 32'(gif.state_chg), 1);
        n = 0; c3 = 0; c2 = 0; c1 = 0; chg = 0;
        while (gif.state == 2'd1 && n < 4000) begin
            if (gif.cd_sec == 2'd3) c3++;
            if (gif.cd_sec == 2'd2) c2++;
            if (gif.cd_sec == 2'd1) c1++;
            if (gif.state_chg) chg++;
            @(negedge clk);
            n++;
        end
        chk("cd_to_ingame_state", 32'(gif.state), 2);
        chk("cd_len_in_range", 32'(n >= 2991 && n <= 3000), 1);
        chk("cd_sec3_cycles_in_range", 32'(c3 >= 991 && c3 <= 1000), 1);
        chk("cd_sec2_cycles", 32'(c2), 1000);
        chk("cd_sec1_cycles", 32'(c1), 1000);
        chk("cd_sec_cover", 32'(c3 + c2 + c1), 32'(n));
        chk("cd_chg_pulses", 32'(chg), 1);
        chk("ingame_chg", 32'(gif.state_chg), 1);
        chk("ingame_cd_sec", 32'(gif.cd_sec), 0);
        @(negedge clk);
        chk("ingame_chg_drop", 32'(gif.state_chg), 0);

        // Selection frozen outside SELECT; ENTER ignored in INGAME
        press(KEY_UP, 1'b0);
        chk("ingame_up_value", 32'(gif.value), 25);
        press(KEY_RIGHT, 1'b0);
        chk("ingame_right_mode", 32'(gif.mode), 1);
        press(KEY_ENTER, 1'b0);
        chk("ingame_enter_state", 32'(gif.state), 2);

        // finish -> FINISH -> ENTER -> SELECT
        @(negedge clk);
        gif.finish = 1'b1;
        @(negedge clk);
        gif.finish = 1'b0;
        chk("finish_state", 32'(gif.state), 3);
        chk("finish_chg", 32'(gif.state_chg), 1);
        press(KEY_UP, 1'b0);
        chk("finish_up_value", 32'(gif.value), 25);
        press(KEY_ENTER, 1'b0);
        chk("finish_enter_state", 32'(gif.state), 0);
        chk("finish_enter_chg", 32'(gif.state_chg), 1);

        // ESC during countdown, then a fresh countdown starts at 3
        press(KEY_ENTER, 1'b0);
        n = 0;
        while (gif.cd_sec != 2'd2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_cd_sec2", 32'(gif.cd_sec), 2);
        press(KEY_ESC, 1'b0);
        chk("esc_cd_state", 32'(gif.state), 0);
        chk("esc_cd_sec", 32'(gif.cd_sec), 0);
        chk("esc_cd_chg", 32'(gif.state_chg), 1);
        press(KEY_ENTER, 1'b0);
        chk("reenter_cd_sec", 32'(gif.cd_sec), 3);

        // ESC beats finish in the same cycle
        wait_state(2'd2, 3500, n);
        chk("reach_ingame2", 32'(gif.state), 2);
        press(KEY_ESC, 1'b1);
        chk("esc_finish_state", 32'(gif.state), 0);
        @(negedge clk);
        chk("esc_finish_hold", 32'(gif.state), 0);

        // FINISH hold behaviour
        press(KEY_ENTER, 1'b0);
        wait_state(2'd2, 3500, n);
        chk("reach_ingame3", 32'(gif.state), 2);
        @(negedge clk);
        gif.finish = 1'b1;
        @(negedge clk);
        gif.finish = 1'b0;
        chk("finish2_state", 32'(gif.state), 3);
`ifdef AUTO_RETURN_EN
        wait_state(2'd0, 11000, n);
        chk("auto_return_state", 32'(gif.state), 0);
        chk("auto_return_len_in_range", 32'(n >= 9991 && n <= 10000), 1);
        chk("auto_return_chg", 32'(gif.state_chg), 1);
`else
        repeat (10500) @(negedge clk);
        chk("finish_held_state", 32'(gif.state), 3);
        press(KEY_ESC, 1'b0);
        chk("finish_esc_state", 32'(gif.state), 0);
`endif

        // Asynchronous reset in the middle of a countdown
        press(KEY_RIGHT, 1'b0);
        chk("pre_rst_mode", 32'(gif.mode), 0);
        press(KEY_ENTER, 1'b0);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(gif.state), 0);
        chk("async_rst_mode", 32'(gif.mode), 1);
        chk("async_rst_value", 32'(gif.value), 20);
        chk("async_rst_cd_sec", 32'(gif.cd_sec), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3500) @(negedge clk);
        chk("post_rst_state", 32'(gif.state), 0);
        chk("post_rst_chg", 32'(gif.state_chg), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
